// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor count, debounce depth and direction codes.
package elevator_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int DEB_TICKS  = 3;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_BOTH = 2'b11
    } dir_e;

    // True when the served direction releases the hall up call.
    function automatic logic serves_up(input logic [1:0] dir);
        return (dir & DIR_UP) != 2'b00;
    endfunction

    // True when the served direction releases the hall down call.
    function automatic logic serves_down(input logic [1:0] dir);
        return (dir & DIR_DOWN) != 2'b00;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw button: 2-flop synchronizer, tick-sampled debouncer, rising-edge press pulse.
module button_debouncer #(
    parameter int DEB_TICKS = elevator_pkg::DEB_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    logic w_diff;
    logic w_done;

    // A sample disagreeing with the level on the last needed tick flips the level.
    assign w_diff  = r_sync2 ^ r_level;
    assign w_done  = tick & w_diff & (r_cnt == CW'(DEB_TICKS - 1));
    // Press is the cycle in which the debounced level is about to rise.
    assign o_press = w_done & r_sync2;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing tick samples; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (tick) begin
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_register.sv
// Elevator call register: debounces all buttons, latches hall/car calls, reports call position.
module call_register #(
    parameter int DEB_TICKS  = elevator_pkg::DEB_TICKS,
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          en,
    input  logic [NUM_FLOORS-1:0]         hall_up_btn,
    input  logic [NUM_FLOORS-1:0]         hall_down_btn,
    input  logic [NUM_FLOORS-1:0]         car_btn,
    input  logic [$clog2(NUM_FLOORS)-1:0] floor,
    input  logic                          serve_valid,
    input  logic [$clog2(NUM_FLOORS)-1:0] serve_floor,
    input  logic [1:0]                    serve_dir,
    output logic [NUM_FLOORS-1:0]         up,
    output logic [NUM_FLOORS-1:0]         down,
    output logic [NUM_FLOORS-1:0]         floor_btn,
    output logic                          req_above,
    output logic                          req_below,
    output logic                          req_here
);

    import elevator_pkg::*;

    // No up call exists at the top floor, no down call at the bottom floor.
    localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    logic [NUM_FLOORS-1:0] r_up;
    logic [NUM_FLOORS-1:0] r_down;
    logic [NUM_FLOORS-1:0] r_car;

    logic [NUM_FLOORS-1:0] w_press_up;
    logic [NUM_FLOORS-1:0] w_press_dn;
    logic [NUM_FLOORS-1:0] w_press_car;
    logic [NUM_FLOORS-1:0] w_serve_sel;
    logic [NUM_FLOORS-1:0] w_clr_up;
    logic [NUM_FLOORS-1:0] w_clr_dn;
    logic [NUM_FLOORS-1:0] w_clr_car;
    logic [NUM_FLOORS-1:0] w_any;
    logic                  w_above;
    logic                  w_below;
    logic                  w_here;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
            button_debouncer #(.DEB_TICKS(DEB_TICKS)) u_up (
                .clk(clk), .rst(rst), .tick(tick),
                .i_btn(hall_up_btn[gi]), .o_press(w_press_up[gi])
            );
            button_debouncer #(.DEB_TICKS(DEB_TICKS)) u_dn (
                .clk(clk), .rst(rst), .tick(tick),
                .i_btn(hall_down_btn[gi]), .o_press(w_press_dn[gi])
            );
            button_debouncer #(.DEB_TICKS(DEB_TICKS)) u_car (
                .clk(clk), .rst(rst), .tick(tick),
                .i_btn(car_btn[gi]), .o_press(w_press_car[gi])
            );
        end
    endgenerate

    // Clears for the floor being served; a car call always goes, hall calls per direction.
    assign w_serve_sel = serve_valid ? (NUM_FLOORS'(1) << serve_floor) : '0;
    assign w_clr_car   = w_serve_sel;
    assign w_clr_up    = serves_up(serve_dir)   ? w_serve_sel : '0;
    assign w_clr_dn    = serves_down(serve_dir) ? w_serve_sel : '0;

    // Latch calls: sets accumulate, clears beat sets, disable empties everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up   <= '0;
            r_down <= '0;
            r_car  <= '0;
        end else if (!en) begin
            r_up   <= '0;
            r_down <= '0;
            r_car  <= '0;
        end else begin
            r_up   <= (r_up   | w_press_up)  & ~w_clr_up  & UP_MASK;
            r_down <= (r_down | w_press_dn)  & ~w_clr_dn  & DN_MASK;
            r_car  <= (r_car  | w_press_car) & ~w_clr_car;
        end
    end

    assign w_any = r_up | r_down | r_car;

    // Locate pending calls relative to the car's current floor.
    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        w_here  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_any[i]) begin
                if (i > int'(floor))  w_above = 1'b1;
                if (i < int'(floor))  w_below = 1'b1;
                if (i == int'(floor)) w_here  = 1'b1;
            end
        end
    end

    assign up        = r_up;
    assign down      = r_down;
    assign floor_btn = r_car;
    assign req_above = w_above;
    assign req_below = w_below;
    assign req_here  = w_here;

endmodule

// File: doc/call_register.md
CALL_REGISTER -- requirements
Module: call_register

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 3: consecutive stable tick samples required before a debounced level change.
REQ-002 SHALL have parameter NUM_FLOORS, default 8: number of floors, equal to the request-vector width.
REQ-003 clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle sample strobe for debouncing (about 1 kHz).
REQ-006 en  input  1  call acceptance enable; low while the system is off (status 0).
REQ-007 hall_up_btn  input  8  raw hall up buttons, bit i = floor i, asynchronous.
REQ-008 hall_down_btn  input  8  raw hall down buttons, asynchronous.
REQ-009 car_btn  input  8  raw in-car floor buttons, asynchronous.
REQ-010 floor  input  3  current car floor, 0-based.
REQ-011 serve_valid  input  1  one-cycle pulse: car is stopped with doors opening at serve_floor.
REQ-012 serve_floor  input  3  floor being served.
REQ-013 serve_dir  input  2  direction being served: 00 none, 01 up, 10 down, 11 both.
REQ-014 up  output  8  latched hall up calls; feeds the display block's up input.
REQ-015 down  output  8  latched hall down calls; feeds the display block's down input.
REQ-016 floor_btn  output  8  latched car calls.
REQ-017 req_above  output  1  a call of any type exists at a floor greater than floor.
REQ-018 req_below  output  1  a call of any type exists at a floor less than floor.
REQ-019 req_here  output  1  a call of any type exists at floor.

Function
REQ-020 Each raw button SHALL pass through a 2-flop synchronizer before debouncing.
REQ-021 The debounced level SHALL change only after DEB_TICKS consecutive tick samples differ from the current debounced level; any agreeing sample resets the count.
REQ-022 A press event SHALL be a 0->1 transition of the debounced level, one clk cycle wide.
REQ-023 A press event with en=1 SHALL set the matching latch bit in the next cycle; a bit already set stays set; releasing the button SHALL NOT clear it.
REQ-024 up[7] and down[0] SHALL be held at 0; presses on those buttons SHALL be ignored.
REQ-025 serve_valid SHALL clear floor_btn[serve_floor] in the next cycle.
REQ-026 serve_valid SHALL also clear up[serve_floor] if serve_dir[0]=1, and down[serve_floor] if serve_dir[1]=1.
REQ-027 If a set and a clear hit the same bit in the same cycle, the clear SHALL win (the car is already there).
REQ-028 en=0 SHALL clear all latches in the next cycle and block all sets; debouncers keep running.
REQ-029 req_above, req_below and req_here SHALL be combinational from the registered latches and floor.
REQ-030 req_above SHALL be 0 when floor=7, and req_below SHALL be 0 when floor=0.
REQ-031 serve_floor values outside 0..NUM_FLOORS-1 cannot occur when NUM_FLOORS=8 (3-bit port); no wrap-around handling is required.

Reset
REQ-032 rst high SHALL immediately zero up, down, floor_btn, all synchronizers, debounced levels and counters.
REQ-033 A button held through reset release SHALL register only after DEB_TICKS ticks, as a new press.
REQ-034 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-035 NUM_FLOORS, the direction encodings (DIR_NONE/UP/DOWN/BOTH) and the default DEB_TICKS SHALL live in shared package elevator_pkg.
REQ-036 A sub-module button_debouncer (synchronizer, counter, edge output) SHALL be instantiated once per button, 24 instances.

Verification
REQ-037 Hold car_btn[5] for 3 ticks -> floor_btn=8'h20 one cycle after the third tick; release -> remains 8'h20.
REQ-038 Glitch hall_up_btn[2] for 2 ticks, then release -> up stays 8'h00.
REQ-039 up=8'h04 and down=8'h04, then serve_valid, serve_floor=2, serve_dir=01 -> up=8'h00, down=8'h04.
REQ-040 Press event on down[3] in the same cycle as serve_valid, serve_floor=3, serve_dir=10 -> down[3]=0.
REQ-041 hall_up_btn[7] and hall_down_btn[0] held -> up[7]=0 and down[0]=0.
REQ-042 floor_btn=8'h81 with floor=3 -> req_above=1, req_below=1, req_here=0; then en=0 -> all outputs 0 next cycle; rst mid-press -> all outputs 0 at once.
